pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline stage register. Successor to the fixed-field, always-advancing ID/EX-style stage registers.
- Carries a control bundle and a data bundle between two pipeline stages with a valid/ready handshake and a 2-entry skid buffer.
- Supports flush (bubble insertion) for branch/jump redirect.
- Drop-in between any two stages of the RV32I pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- CTRL_W, 19, width of control bundle; zeroed on bubble/flush.
- DATA_W, 165, width of data bundle (operands, PC, imm, register indices).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  upstream entry present
- in_ready  output  1  stage can accept (registered)
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream data bundle
- out_valid  output  1  entry presented downstream
- out_ready  input  1  downstream accepts
- out_ctrl  output  CTRL_W  head entry control; all-zero when out_valid=0
- out_data  output  DATA_W  head entry data
- occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Storage: main register (drives out_*) and skid register. All outputs registered.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- State EMPTY (occ 0):
  - push -> main<=in, ONE.
  - no push -> stay.
- State ONE (occ 1):
  - push & pop -> main<=in, stay ONE.
  - push only -> skid<=in, TWO, in_ready<=0.
  - pop only -> EMPTY, out_ctrl<=0.
  - neither -> hold.
- State TWO (occ 2): in_ready=0, so push is impossible.
  - pop -> main<=skid, ONE, in_ready<=1.
  - no pop -> hold all.
- in_ready = 1 in EMPTY/ONE, 0 in TWO. Upstream sees a full-throughput path: one transfer per cycle in steady state, latency 1 cycle in->out.
- Stall: out_ready=0 holds out_ctrl/out_data/out_valid stable until pop. Values must not change while out_valid=1 and out_ready=0.
- Bubble invariant: out_valid=0 implies out_ctrl=0. out_data when invalid retains its last value, except after reset/flush, when it is 0.
- Flush:
  - Next cycle: EMPTY, occupancy=0, out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
  - Any push in the flush cycle is discarded.
  - A pop in the flush cycle completes normally; downstream sampled it.
  - Flush has priority over push, pop and stall.
- Reset (reset=1 at clk edge): same state as flush. All outputs 0 except in_ready=1. Reset dominates flush.
  - Reset asserted mid-operation discards both entries.
  - While reset=1, no handshake is honoured.
- in_valid may drop without a handshake; the stage only samples on push.
- No combinational path from out_ready to in_ready or from in_* to out_*.

Optional Feature:
- Macro PIPE_SKID_STATS_EN.
- When defined, adds:
  - output stall_cnt [31:0]: increments each cycle out_valid=1 and out_ready=0.
  - output flush_cnt [31:0]: increments each cycle flush=1 and reset=0.
  - Both counters wrap at 2^32, are cleared by reset, and are not cleared by flush.
- When undefined, these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Reset, then idle: reset=1 for 2 cycles then 0 -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
- Streaming: out_ready=1, push ctrl=0x00001..0x00005 on consecutive cycles -> same values on out_ctrl one cycle later each, in_ready stays 1, occupancy=1 throughout.
- Stall/skid: push A=0x11, B=0x22 with out_ready=0 ->
  - occupancy=2, in_ready=0, out_ctrl=0x11 held.
  - Raise out_ready -> 0x11 then 0x22 popped on consecutive cycles, in_ready=1 one cycle after first pop, then occupancy=0.
- Flush in TWO: hold 2 entries, assert flush with in_valid=1 (C=0x33) -> next cycle occupancy=0, out_valid=0, out_ctrl=0, C never appears.
- Flush+reset priority: assert flush and reset together in ONE -> reset state. With PIPE_SKID_STATS_EN, flush_cnt=0 and stall_cnt=0.
- Stats: with PIPE_SKID_STATS_EN, 3 stall cycles then 2 flush cycles -> stall_cnt=3, flush_cnt=2.

Source files
------------

// File: rtl/pipe_skid_stage_if.sv
// ============================================================================
// Module   : pipe_skid_stage_if
// Purpose  : Handshake, payload and flush bundle between two pipeline stages.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_skid_stage_if #(
  parameter int CTRL_W = 19,
  parameter int DATA_W = 165
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  // The stage itself.
  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  // Whatever drives the stage (neighbouring stages / pipeline control).
  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );
endinterface

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : Elastic pipeline register with 2-entry skid buffer and flush.
//            Optional PIPE_SKID_STATS_EN adds stall_cnt / flush_cnt counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage #(
  parameter int CTRL_W = 19,
  parameter int DATA_W = 165
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pipe_skid_stage_if.slave  bus
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] main_ctrl_nxt;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] main_data_nxt;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CTRL_W-1:0] skid_ctrl_nxt;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_data_nxt;

  logic              valid_q;
  logic              valid_nxt;
  logic              ready_q;
  logic              ready_nxt;
  logic [1:0]        occ_q;
  logic [1:0]        occ_nxt;

  logic              push;
  logic              pop;

  // Handshakes qualify only on registered flags, so no input reaches an output.
  assign push = bus.in_valid & ready_q;
  assign pop  = valid_q & bus.out_ready;

  always_comb begin
    state_nxt     = state;
    main_ctrl_nxt = main_ctrl;
    main_data_nxt = main_data;
    skid_ctrl_nxt = skid_ctrl;
    skid_data_nxt = skid_data;

    if (bus.flush) begin
      state_nxt     = ST_EMPTY;
      main_ctrl_nxt = '0;
      main_data_nxt = '0;
      skid_ctrl_nxt = '0;
      skid_data_nxt = '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            main_ctrl_nxt = bus.in_ctrl;
            main_data_nxt = bus.in_data;
            state_nxt     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_ctrl_nxt = bus.in_ctrl;
            main_data_nxt = bus.in_data;
          end else if (push) begin
            skid_ctrl_nxt = bus.in_ctrl;
            skid_data_nxt = bus.in_data;
            state_nxt     = ST_TWO;
          end else if (pop) begin
            // Bubble: control cleared, data keeps its last value.
            main_ctrl_nxt = '0;
            state_nxt     = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_ctrl_nxt = skid_ctrl;
            main_data_nxt = skid_data;
            state_nxt     = ST_ONE;
          end
        end
        default: begin
          state_nxt     = ST_EMPTY;
          main_ctrl_nxt = '0;
          main_data_nxt = '0;
        end
      endcase
    end

    valid_nxt = (state_nxt != ST_EMPTY);
    ready_nxt = (state_nxt != ST_TWO);
    case (state_nxt)
      ST_ONE:  occ_nxt = 2'd1;
      ST_TWO:  occ_nxt = 2'd2;
      default: occ_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      occ_q     <= 2'd0;
    end else begin
      state     <= state_nxt;
      main_ctrl <= main_ctrl_nxt;
      main_data <= main_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
      skid_data <= skid_data_nxt;
      valid_q   <= valid_nxt;
      ready_q   <= ready_nxt;
      occ_q     <= occ_nxt;
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_ctrl  = main_ctrl;
  assign bus.out_data  = main_data;
  assign bus.occupancy = occ_q;

`ifdef PIPE_SKID_STATS_EN
  // Counters survive flush on purpose; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (valid_q && !bus.out_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bus.flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed vector table, a stall/flush
// sequence, then random traffic against a queue-based reference model.
`default_nettype none

module tb_pipe_skid_stage;
  localparam int CTRL_W = 19;
  localparam int DATA_W = 165;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_skid_stage_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

`ifdef PIPE_SKID_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // Reference model: a FIFO of at most two entries.
  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            q[$];
  logic [DATA_W-1:0] m_last_data = '0;
  int unsigned       m_stall = 0;
  int unsigned       m_flush = 0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic              rst;
    logic              fl;
    logic              iv;
    logic [CTRL_W-1:0] ctrl;
    logic              ordy;
    logic              ev;
    logic [CTRL_W-1:0] ectrl;
    logic              erdy;
    logic [1:0]        eocc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [DATA_W-1:0] data_of(input logic [CTRL_W-1:0] c);
    return DATA_W'({8{c}}) ^ (DATA_W'(1) << 160);
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic ordy);
    reset        = rst;
    bus.flush    = fl;
    bus.in_valid = iv;
    bus.in_ctrl  = c;
    bus.in_data  = d;
    bus.out_ready = ordy;
  endtask

  // Apply the architectural rules to the inputs present at this clock edge.
  task automatic model_edge();
    bit had_valid;
    bit could_accept;
    had_valid    = (q.size() > 0);
    could_accept = (q.size() < 2);
    if (reset) begin
      q.delete();
      m_last_data = '0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (had_valid && !bus.out_ready) m_stall++;
      if (bus.flush) begin
        m_flush++;
        q.delete();
        m_last_data = '0;
      end else begin
        if (had_valid && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && could_accept) q.push_back('{bus.in_ctrl, bus.in_data});
        if (q.size() > 0) m_last_data = q[0].data;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [CTRL_W-1:0] ec;
    logic [DATA_W-1:0] ed;
    ec = (q.size() > 0) ? q[0].ctrl : '0;
    ed = (q.size() > 0) ? q[0].data : m_last_data;
    check({tag, " out_valid"}, DATA_W'(bus.out_valid), DATA_W'(q.size() > 0));
    check({tag, " out_ctrl"},  DATA_W'(bus.out_ctrl), DATA_W'(ec));
    check({tag, " out_data"},  bus.out_data, ed);
    check({tag, " in_ready"},  DATA_W'(bus.in_ready), DATA_W'(q.size() < 2));
    check({tag, " occupancy"}, DATA_W'(bus.occupancy), DATA_W'(q.size()));
`ifdef PIPE_SKID_STATS_EN
    check({tag, " stall_cnt"}, DATA_W'(stall_cnt), DATA_W'(m_stall));
    check({tag, " flush_cnt"}, DATA_W'(flush_cnt), DATA_W'(m_flush));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  task automatic add(input logic rst, input logic fl, input logic iv,
                     input logic [CTRL_W-1:0] c, input logic ordy,
                     input logic ev, input logic [CTRL_W-1:0] ec,
                     input logic erdy, input logic [1:0] eocc);
    tbl.push_back('{rst, fl, iv, c, ordy, ev, ec, erdy, eocc});
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

    //   rst fl iv ctrl       ordy | ev ectrl      erdy occ
    add(1, 0, 0, 19'h00000, 0,   0, 19'h00000, 1, 2'd0);  // reset
    add(1, 0, 1, 19'h00005, 1,   0, 19'h00000, 1, 2'd0);  // no handshake in reset
    add(0, 0, 0, 19'h00000, 1,   0, 19'h00000, 1, 2'd0);  // idle
    add(0, 0, 1, 19'h00001, 1,   1, 19'h00001, 1, 2'd1);  // streaming
    add(0, 0, 1, 19'h00002, 1,   1, 19'h00002, 1, 2'd1);
    add(0, 0, 1, 19'h00003, 1,   1, 19'h00003, 1, 2'd1);
    add(0, 0, 1, 19'h00004, 1,   1, 19'h00004, 1, 2'd1);
    add(0, 0, 1, 19'h00005, 1,   1, 19'h00005, 1, 2'd1);
    add(0, 0, 0, 19'h00000, 1,   0, 19'h00000, 1, 2'd0);  // drain
    add(0, 0, 1, 19'h00011, 0,   1, 19'h00011, 1, 2'd1);  // stall / skid
    add(0, 0, 1, 19'h00022, 0,   1, 19'h00011, 0, 2'd2);
    add(0, 0, 1, 19'h00099, 0,   1, 19'h00011, 0, 2'd2);  // full: not accepted
    add(0, 0, 0, 19'h00000, 1,   1, 19'h00022, 1, 2'd1);
    add(0, 0, 0, 19'h00000, 1,   0, 19'h00000, 1, 2'd0);
    add(0, 0, 1, 19'h00044, 0,   1, 19'h00044, 1, 2'd1);  // flush in TWO
    add(0, 0, 1, 19'h00055, 0,   1, 19'h00044, 0, 2'd2);
    add(0, 1, 1, 19'h00033, 0,   0, 19'h00000, 1, 2'd0);
    add(0, 0, 0, 19'h00000, 1,   0, 19'h00000, 1, 2'd0);
    add(0, 0, 1, 19'h00066, 0,   1, 19'h00066, 1, 2'd1);  // flush+reset in ONE
    add(1, 1, 1, 19'h00077, 1,   0, 19'h00000, 1, 2'd0);
    add(0, 0, 1, 19'h00088, 0,   1, 19'h00088, 1, 2'd1);  // flush with pop in ONE
    add(0, 1, 1, 19'h00099, 1,   0, 19'h00000, 1, 2'd0);
    add(0, 0, 0, 19'h00000, 0,   0, 19'h00000, 1, 2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ctrl, data_of(tbl[i].ctrl), tbl[i].ordy);
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl out_valid", i), DATA_W'(bus.out_valid), DATA_W'(tbl[i].ev));
      check($sformatf("vec%0d tbl out_ctrl", i), DATA_W'(bus.out_ctrl), DATA_W'(tbl[i].ectrl));
      check($sformatf("vec%0d tbl in_ready", i), DATA_W'(bus.in_ready), DATA_W'(tbl[i].erdy));
      check($sformatf("vec%0d tbl occupancy", i), DATA_W'(bus.occupancy), DATA_W'(tbl[i].eocc));
    end

    // Three stall cycles then two flush cycles, starting from reset.
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    step("seq reset");
    drive(1'b0, 1'b0, 1'b1, 19'h0000A, data_of(19'h0000A), 1'b0);
    step("seq push");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      step($sformatf("seq stall%0d", i));
      check($sformatf("seq stall%0d held ctrl", i), DATA_W'(bus.out_ctrl), DATA_W'(19'h0000A));
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
      step($sformatf("seq flush%0d", i));
    end
    check("seq data zero after flush", bus.out_data, '0);
`ifdef PIPE_SKID_STATS_EN
    check("seq stall_cnt", DATA_W'(stall_cnt), DATA_W'(32'd3));
    check("seq flush_cnt", DATA_W'(flush_cnt), DATA_W'(32'd2));
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [191:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      drive($urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 70,
            CTRL_W'($urandom),
            r[DATA_W-1:0],
            $urandom_range(0, 99) < 60);
      step($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
